// File: rtl/tag_alloc_r.sv
// Circular first-zero finder: scans x downward starting at bit pos-1
// (wrapping modulo W) and reports the first clear bit it meets.
module tag_alloc_r #(
   parameter int W = 16
) (
   input  logic [W-1:0]         x,
   input  logic [$clog2(W)-1:0] pos,
   output logic [$clog2(W)-1:0] y_enc,
   output logic                 any
);
   localparam int TW = $clog2(W);

   logic [TW-1:0] idx;

   // Walk from the farthest candidate (pos itself) towards pos-1 so the
   // nearest clear bit below pos is the last one written and wins.
   always_comb begin
      any   = 1'b0;
      y_enc = '0;
      idx   = '0;
      for (int i = W; i >= 1; i--) begin
         idx = pos - i[TW-1:0];
         if (!x[idx]) begin
            any   = 1'b1;
            y_enc = idx;
         end
      end
   end
endmodule

// File: rtl/tag_alloc.sv
// Tag allocator: keeps one registered tag on offer, hands tags out in
// descending circular order, and accepts releases of held tags.
module tag_alloc #(
   parameter int W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush_i,
   output logic                 alloc_vld_o,
   output logic [$clog2(W)-1:0] alloc_tag_o,
   input  logic                 alloc_rdy_i,
   input  logic                 free_vld_i,
   input  logic [$clog2(W)-1:0] free_tag_i,
   output logic [$clog2(W):0]   count_o,
   output logic                 full_o,
   output logic                 err_o
);
   localparam int TW = $clog2(W);

   logic [W-1:0]  occ;
   logic [TW-1:0] ptr;
   logic          offer_vld;
   logic [TW-1:0] offer_tag;
   logic [TW:0]   count;
   logic          err;

   logic          accept;
   logic          legal_free;
   logic          can_load;
   logic [W-1:0]  free_mask;
   logic [W-1:0]  load_mask;
   logic [W-1:0]  occ_free;
   logic [TW-1:0] found_tag;
   logic          found;

   // A free is honoured only for a held tag that is not the one on offer,
   // and never when nothing is counted as accepted.
   always_comb begin
      accept     = offer_vld & alloc_rdy_i;
      legal_free = free_vld_i & occ[free_tag_i]
                   & ~(offer_vld && (free_tag_i == offer_tag))
                   & (count != '0);
      free_mask  = legal_free ? ({{(W-1){1'b0}}, 1'b1} << free_tag_i) : '0;
      occ_free   = occ & ~free_mask;
      can_load   = (~offer_vld | accept) & found;
      load_mask  = can_load ? ({{(W-1){1'b0}}, 1'b1} << found_tag) : '0;
   end

   // The search sees same-cycle frees so a released tag is reusable at once.
   tag_alloc_r #(.W(W)) r (
      .x     (occ_free),
      .pos   (ptr),
      .y_enc (found_tag),
      .any   (found)
   );

   // Allocator state; reset beats flush, flush beats every other input.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ       <= '0;
         ptr       <= '0;
         offer_vld <= 1'b0;
         offer_tag <= '0;
         count     <= '0;
         err       <= 1'b0;
      end else if (flush_i) begin
         occ       <= '0;
         ptr       <= '0;
         offer_vld <= 1'b0;
         count     <= '0;
      end else begin
         occ <= occ_free | load_mask;
         if (can_load) begin
            offer_vld <= 1'b1;
            offer_tag <= found_tag;
            ptr       <= found_tag;
         end else if (accept) begin
            offer_vld <= 1'b0;
         end
         if (accept && !legal_free)
            count <= count + 1'b1;
         else if (!accept && legal_free)
            count <= count - 1'b1;
         if (free_vld_i && !legal_free)
            err <= 1'b1;
      end
   end

   assign alloc_vld_o = offer_vld;
   assign alloc_tag_o = offer_tag;
   assign count_o     = count;
   assign full_o      = (&occ) & ~offer_vld;
   assign err_o       = err;
endmodule

// File: tb/tb_tag_alloc.sv
// Directed bench for tag_alloc (W=16): accepted tags are checked by a
// scoreboard monitor, status outputs by inline checks after each edge.
module tb_tag_alloc;
   localparam int W  = 16;
   localparam int TW = $clog2(W);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush_i;
   logic          alloc_vld_o;
   logic [TW-1:0] alloc_tag_o;
   logic          alloc_rdy_i;
   logic          free_vld_i;
   logic [TW-1:0] free_tag_i;
   logic [TW:0]   count_o;
   logic          full_o;
   logic          err_o;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   tag_alloc #(.W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush_i),
      .alloc_vld_o (alloc_vld_o),
      .alloc_tag_o (alloc_tag_o),
      .alloc_rdy_i (alloc_rdy_i),
      .free_vld_i  (free_vld_i),
      .free_tag_i  (free_tag_i),
      .count_o     (count_o),
      .full_o      (full_o),
      .err_o       (err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every handshake that will complete at the next edge must
   // match the oldest expected tag.
   always @(negedge clk) begin
      if (rst_n && alloc_vld_o && alloc_rdy_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL accept_unexpected: got tag %0d expected none", alloc_tag_o);
         end else begin
            chk("accept_tag", int'(alloc_tag_o), exp_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; flush_i = 1'b0; alloc_rdy_i = 1'b0;
      free_vld_i = 1'b0; free_tag_i = '0;
      tick(); tick();
      chk("rst_vld", alloc_vld_o, 0);
      chk("rst_tag", alloc_tag_o, 0);
      chk("rst_count", count_o, 0);
      chk("rst_full", full_o, 0);
      chk("rst_err", err_o, 0);

      // Drain all tags with ready held high.
      for (int t = W - 1; t >= 0; t--) exp_q.push_back(t);
      rst_n = 1'b1; alloc_rdy_i = 1'b1;
      tick();
      chk("first_vld", alloc_vld_o, 1);
      chk("first_tag", alloc_tag_o, 15);
      chk("first_count", count_o, 0);
      repeat (W) tick();
      alloc_rdy_i = 1'b0;
      chk("drain_count", count_o, 16);
      chk("drain_full", full_o, 1);
      chk("drain_vld", alloc_vld_o, 0);

      // Free 9 from full: offered next cycle.
      free_vld_i = 1'b1; free_tag_i = 4'd9;
      tick();
      free_vld_i = 1'b0;
      chk("refree_vld", alloc_vld_o, 1);
      chk("refree_tag", alloc_tag_o, 9);
      chk("refree_count", count_o, 15);
      chk("refree_full", full_o, 0);
      tick();
      chk("hold_tag", alloc_tag_o, 9);
      chk("hold_count", count_o, 15);
      exp_q.push_back(9); alloc_rdy_i = 1'b1;
      tick();
      alloc_rdy_i = 1'b0;
      chk("refull_count", count_o, 16);
      chk("refull_full", full_o, 1);

      // Get 7 on offer, then illegally free it.
      free_vld_i = 1'b1; free_tag_i = 4'd7;
      tick();
      chk("off7_tag", alloc_tag_o, 7);
      chk("off7_count", count_o, 15);
      tick();
      free_vld_i = 1'b0;
      chk("ill_err", err_o, 1);
      chk("ill_vld", alloc_vld_o, 1);
      chk("ill_tag", alloc_tag_o, 7);
      chk("ill_count", count_o, 15);
      tick();
      chk("err_sticky", err_o, 1);

      // Accept 7 while freeing 3: search from 6 finds 3.
      exp_q.push_back(7); alloc_rdy_i = 1'b1;
      free_vld_i = 1'b1; free_tag_i = 4'd3;
      tick();
      chk("off3_tag", alloc_tag_o, 3);
      chk("off3_count", count_o, 15);
      // Accept 3 while freeing 12: count net unchanged, next offer 12.
      exp_q.push_back(3); free_tag_i = 4'd12;
      tick();
      alloc_rdy_i = 1'b0; free_vld_i = 1'b0;
      chk("accfree_count", count_o, 15);
      chk("accfree_tag", alloc_tag_o, 12);
      chk("accfree_vld", alloc_vld_o, 1);

      // Flush, then hold 5 tags with an offer pending and flush again.
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("fl1_count", count_o, 0);
      chk("fl1_vld", alloc_vld_o, 0);
      tick();
      chk("fl1_tag", alloc_tag_o, 15);
      for (int t = 15; t >= 11; t--) exp_q.push_back(t);
      alloc_rdy_i = 1'b1;
      repeat (5) tick();
      alloc_rdy_i = 1'b0;
      chk("held5_count", count_o, 5);
      chk("held5_tag", alloc_tag_o, 10);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("fl2_count", count_o, 0);
      chk("fl2_vld", alloc_vld_o, 0);
      chk("fl2_err", err_o, 1);
      tick();
      chk("fl2_vld_next", alloc_vld_o, 1);
      chk("fl2_tag_next", alloc_tag_o, 15);

      // Reset mid-handshake: no acceptance, everything cleared.
      alloc_rdy_i = 1'b1; rst_n = 1'b0;
      tick();
      alloc_rdy_i = 1'b0;
      chk("mrst_vld", alloc_vld_o, 0);
      chk("mrst_tag", alloc_tag_o, 0);
      chk("mrst_count", count_o, 0);
      chk("mrst_full", full_o, 0);
      chk("mrst_err", err_o, 0);
      rst_n = 1'b1;
      tick();
      chk("post_tag", alloc_tag_o, 15);

      // Free with nothing held is illegal.
      free_vld_i = 1'b1; free_tag_i = 4'd4;
      tick();
      free_vld_i = 1'b0;
      chk("empty_free_err", err_o, 1);
      chk("empty_free_count", count_o, 0);
      tick(); tick();
      chk("queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/tag_alloc.md
TAG_ALLOC -- requirements
Module: tag_alloc

Interface
REQ-001 SHALL have parameter W, default 16, meaning number of tags; W is a power of two and at least 2.
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock.
REQ-003 SHALL have port rst_n, input, 1 bit, meaning reset; synchronous, active-low.
REQ-004 SHALL have port flush_i, input, 1 bit, meaning release all tags and drop any current offer.
REQ-005 SHALL have port alloc_vld_o, output, 1 bit, meaning a tag is on offer.
REQ-006 SHALL have port alloc_tag_o, output, $clog2(W) bits, meaning the offered tag.
REQ-007 SHALL have port alloc_rdy_i, input, 1 bit, meaning the consumer accepts the offer.
REQ-008 SHALL have port free_vld_i, input, 1 bit, meaning a tag release this cycle.
REQ-009 SHALL have port free_tag_i, input, $clog2(W) bits, meaning the tag being released.
REQ-010 SHALL have port count_o, output, $clog2(W)+1 bits, meaning the number of accepted, unreleased tags.
REQ-011 SHALL have port full_o, output, 1 bit, meaning no tag is free and none is offered.
REQ-012 SHALL have port err_o, output, 1 bit, meaning sticky illegal-free flag.

Function
REQ-013 SHALL hold state in registers: occ[W-1:0] (busy = 1, includes the offered tag), ptr, offer_vld, offer_tag, count and err.
REQ-014 SHALL search occ circularly downward, starting at bit ptr-1 (mod W); the result is the first 0 found.
REQ-015 SHALL drive alloc_vld_o and alloc_tag_o directly from offer_vld and offer_tag, with no combinational path from inputs.
REQ-016 SHALL define acceptance as alloc_vld_o & alloc_rdy_i; on acceptance, count increments and offer_vld clears unless it is reloaded in the same cycle.
REQ-017 SHALL load the search result into offer_tag and set occ[result] and offer_vld when (offer_vld == 0 or the offer is accepted) and a free bit exists; load-to-valid latency is 1 cycle.
REQ-018 SHALL compute the search in REQ-017 on occ including any same-cycle legal free, so a tag freed in cycle N can be offered in cycle N+1.
REQ-019 SHALL set ptr to the loaded tag on each load, so successive offers descend W-1, W-2, ..., 0, then wrap to W-1.
REQ-020 SHALL keep an offered tag stable until accepted; frees never alter offer_tag.
REQ-021 SHALL treat a free as legal only when occ[free_tag_i] == 1, free_tag_i is not the currently offered tag, and count > 0.
REQ-022 SHALL, on a legal free, clear occ[free_tag_i] and decrement count.
REQ-023 SHALL, on an illegal free, leave state unchanged and set err.
REQ-024 SHALL, on simultaneous acceptance and legal free, leave count net unchanged.
REQ-025 SHALL assert full_o when occ == all-ones and offer_vld == 0.
REQ-026 SHALL, on flush_i (if rst_n high), clear occ, offer_vld and count, set ptr = 0, and leave err unchanged; flush_i has priority over all other inputs; the first offer appears 1 cycle after flush deasserts.

Reset
REQ-027 SHALL, while rst_n == 0 at a clk edge, set occ = 0, ptr = 0, offer_vld = 0, offer_tag = 0, count = 0, err = 0; outputs are then alloc_vld_o = 0, alloc_tag_o = 0, count_o = 0, full_o = 0, err_o = 0.
REQ-028 SHALL give reset priority over flush_i; reset mid-handshake discards the offer with no acceptance.

Structure
REQ-029 SHALL instantiate exactly one sub-module, r (circular first-zero finder), with inputs x = occ-after-free and pos = ptr, using its y_enc and any outputs.
REQ-030 SHALL place no typedefs in a shared package; the tag width $clog2(W) is a localparam.

Verification
REQ-031 SHALL cover: reset, then alloc_rdy_i held 1 with W=16 -> tags 15,14,...,0 on consecutive cycles, first at cycle 1, count reaching 16, full_o = 1.
REQ-032 SHALL cover: full, then free tag 9 -> cycle+1 alloc_vld_o = 1 with tag 9, count = 15 until accepted.
REQ-033 SHALL cover: tag 7 offered and unaccepted, then free of tag 7 -> err_o = 1 sticky, offer remains tag 7, count unchanged.
REQ-034 SHALL cover: acceptance of tag 3 in the same cycle as a legal free of tag 12 -> count unchanged, next offer follows the downward search from 3.
REQ-035 SHALL cover: flush_i with 5 tags held and an offer pending -> next cycle count = 0, alloc_vld_o = 0; the cycle after, tag 15 is offered.
REQ-036 SHALL cover: rst_n low while alloc_vld_o = 1 and alloc_rdy_i = 1 -> all outputs 0 next cycle, no count increment.
